dice_roller: RTL and testbench

//  Parametrised multi-die roller driving nine-segment LED dice. A held roll input

---
 rtl/dice_roller.sv | 179 +++++++++++++++++
 tb/tb_dice_roller.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roller.sv
// Multi-die roller for nine-segment LED dice: animates while roll is held, slows and settles on release.
// Latency: busy/done/value are registered and change one clk after the deciding edge; seg decodes value with no added delay.
// Backpressure: none. roll and clear are level inputs. Settling ignores them. done is a one-cycle pulse.
//
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset
//   roll   debounced level; high animates the dice, its falling edge starts settling
//   clear  blanks all dice, honoured only while idle
//   value  die i face at [3i+:3], 0 = blank
//   seg    die i pattern at [9i+:9], bits 8..0 = tl,tc,tr,cl,c,cr,bl,bc,br
//   busy   high while rolling or settling
//   done   one-cycle pulse once the final faces are valid
module dice_roller #(
   parameter int          N_DICE       = 2,
   parameter int          MAX_FACE     = 6,
   parameter int          TICK_DIV     = 500000,
   parameter int          SETTLE_STEPS = 8,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                roll,
   input  logic                clear,
   output logic [3*N_DICE-1:0] value,
   output logic [9*N_DICE-1:0] seg,
   output logic                busy,
   output logic                done
);

   // Wide enough for the longest settle period, so no counter ever wraps.
   localparam int CW = $clog2((SETTLE_STEPS + 1) * TICK_DIV + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ROLL   = 2'd1;
   localparam logic [1:0] S_SETTLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] TICK_INC   = CW'(TICK_DIV);
   localparam logic [CW-1:0] PERIOD_INI = CW'(2 * TICK_DIV);
   localparam logic [CW-1:0] K_LAST     = CW'(SETTLE_STEPS - 1);
   localparam logic [CW-1:0] ONE        = CW'(1);

   logic [1:0]             state_q, state_d;
   logic [CW-1:0]          tick_q, tick_d;
   logic [CW-1:0]          period_q, period_d;
   logic [CW-1:0]          k_q, k_d;
   logic [3*N_DICE-1:0]    value_q, value_d;
   logic [15:0]            lfsr_q, lfsr_d;
   logic                   busy_q, done_q;
   logic [3*N_DICE-1:0]    stepped;

   // Advance one face by 1..4 and fold back into 1..MAX_FACE. The 4-bit sum
   // holds the worst case 7+1+3, and a blank die also lands in range.
   function automatic logic [2:0] step_face(input logic [2:0] v, input logic [1:0] r);
      logic [3:0] sum;
      sum = {1'b0, v} + 4'd1 + {2'b00, r};
      if (sum > 4'(MAX_FACE)) begin
         sum = sum - 4'(MAX_FACE);
      end
      return sum[2:0];
   endfunction

   function automatic logic [8:0] seg_of(input logic [2:0] v);
      logic [8:0] p;
      case (v)
         3'd1:    p = 9'h010;
         3'd2:    p = 9'h101;
         3'd3:    p = 9'h111;
         3'd4:    p = 9'h145;
         3'd5:    p = 9'h155;
         3'd6:    p = 9'h16D;
         3'd7:    p = 9'h17D;
         default: p = 9'h000;
      endcase
      return p;
   endfunction

   // Galois LFSR, right shift, taps 16'hB400.
   assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

   // Each die draws its own 2-bit slice of the LFSR.
   always_comb begin
      stepped = '0;
      for (int i = 0; i < N_DICE; i++) begin
         stepped[3*i+:3] = step_face(value_q[3*i+:3], lfsr_q[2*i+:2]);
      end
   end

   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      period_d = period_q;
      k_d      = k_q;
      value_d  = value_q;
      case (state_q)
         S_IDLE: begin
            if (roll) begin
               state_d = S_ROLL;
               tick_d  = '0;
            end else if (clear) begin
               value_d = '0;
            end
         end
         S_ROLL: begin
            if (tick_q == TICK_LAST) begin
               value_d = stepped;
               tick_d  = '0;
            end else begin
               tick_d = tick_q + ONE;
            end
            // A step on the release cycle is kept; only the counters restart.
            if (!roll) begin
               state_d  = S_SETTLE;
               k_d      = '0;
               tick_d   = '0;
               period_d = PERIOD_INI;
            end
         end
         S_SETTLE: begin
            if (tick_q == period_q - ONE) begin
               value_d = stepped;
               tick_d  = '0;
               if (k_q == K_LAST) begin
                  state_d = S_DONE;
               end else begin
                  // Only grows while another step follows, keeping period within CW.
                  k_d      = k_q + ONE;
                  period_d = period_q + TICK_INC;
               end
            end else begin
               tick_d = tick_q + ONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         tick_q   <= '0;
         period_q <= '0;
         k_q      <= '0;
         value_q  <= '0;
         lfsr_q   <= LFSR_SEED;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         period_q <= period_d;
         k_q      <= k_d;
         value_q  <= value_d;
         lfsr_q   <= lfsr_d;
         // Registered from the next state so busy/done line up with state_q.
         busy_q   <= (state_d == S_ROLL) || (state_d == S_SETTLE);
         done_q   <= (state_d == S_DONE);
      end
   end

   always_comb begin
      seg = '0;
      for (int i = 0; i < N_DICE; i++) begin
         seg[9*i+:9] = seg_of(value_q[3*i+:3]);
      end
   end

   assign value = value_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_dice_roller.sv
// Testbench for dice_roller: a reference model predicts when steps fire and the resulting faces.
// Latency: inputs are driven on the falling edge, and outputs are sampled on the next falling edge.
// Backpressure: none; every scenario runs for a fixed number of clock cycles.
module tb_dice_roller;

   localparam int          N    = 2;
   localparam int          MF   = 6;
   localparam int          T    = 4;
   localparam int          S    = 2;
   localparam logic [15:0] SEED = 16'hACE1;
   localparam int          N2   = 5;

   localparam logic [8:0] SEG_TBL [8] = '{9'h000, 9'h010, 9'h101, 9'h111,
                                          9'h145, 9'h155, 9'h16D, 9'h17D};

   logic              clk = 1'b0;
   logic              rst, roll, clear, roll2;
   logic [3*N-1:0]    value;
   logic [9*N-1:0]    seg;
   logic              busy, done;
   logic [3*N2-1:0]   value2;
   logic [9*N2-1:0]   seg2;
   logic              busy2, done2;

   int                n_checks = 0;
   int                n_fail   = 0;
   int                wraps    = 0;
   logic [15:0]       m_lfsr, m_pre;
   int                mv [N];

   always #5 clk = ~clk;

   dice_roller #(.N_DICE(N), .MAX_FACE(MF), .TICK_DIV(T), .SETTLE_STEPS(S), .LFSR_SEED(SEED)) dut (
      .clk(clk), .rst(rst), .roll(roll), .clear(clear),
      .value(value), .seg(seg), .busy(busy), .done(done));

   // Decode check instance covering faces up to 7.
   dice_roller #(.N_DICE(N2), .MAX_FACE(7), .TICK_DIV(2), .SETTLE_STEPS(1), .LFSR_SEED(SEED)) dut7 (
      .clk(clk), .rst(rst), .roll(roll2), .clear(1'b0),
      .value(value2), .seg(seg2), .busy(busy2), .done(done2));

   function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
      return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
   endfunction

   // One face step: add 1 plus a 2-bit random draw, modulo the face range (1..MF).
   function automatic void model_step(input logic [15:0] l);
      for (int i = 0; i < N; i++) begin
         mv[i] = mv[i] + 1 + int'((l >> (2 * i)) & 16'h3);
         if (mv[i] > MF) begin
            mv[i] = mv[i] - MF;
            wraps++;
         end
      end
   endfunction

   function automatic logic [3*N-1:0] exp_value();
      logic [3*N-1:0] ev;
      for (int i = 0; i < N; i++) ev[3*i+:3] = 3'(mv[i]);
      return ev;
   endfunction

   function automatic logic [9*N-1:0] exp_seg();
      logic [9*N-1:0] es;
      for (int i = 0; i < N; i++) es[9*i+:9] = SEG_TBL[mv[i]];
      return es;
   endfunction

   // Advance one clock; m_pre holds the LFSR value that this edge consumed.
   task automatic tick();
      logic [15:0] pre;
      pre = m_lfsr;
      @(negedge clk);
      m_pre  = pre;
      m_lfsr = rst ? SEED : lfsr_adv(pre);
   endtask

   // A roll held for h edges. Step edges come from the timing rules: rolling
   // steps fall at multiples of T up to the release edge, and settle steps follow
   // at intervals of 2T, 3T and so on. rst_at >= 0 asserts reset at that edge.
   task automatic do_roll(input int h, input bit noise, input bit chain, input int rst_at,
                          output int pulses);
      int sedge [S];
      int acc, per, last;
      bit is_step;
      logic exp_b;
      acc = h;
      per = 2 * T;
      for (int j = 0; j < S; j++) begin
         acc += per;
         sedge[j] = acc;
         per += T;
      end
      last   = sedge[S-1];
      pulses = 0;
      for (int e = 0; e <= last + 1; e++) begin
         if (e < h)          roll = 1'b1;
         else if (e == h)    roll = 1'b0;
         else if (e <= last) roll = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         else                roll = chain;
         clear = (noise && e > 0 && e <= last) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (e == rst_at) rst = 1'b1;
         tick();
         if (rst) begin
            for (int i = 0; i < N; i++) mv[i] = 0;
            rst   = 1'b0;
            roll  = 1'b0;
            clear = 1'b0;
            n_checks++;
            if (value !== '0) begin
               n_fail++;
               $display("FAIL rst_mid_value: got %h want 0", value);
            end
            n_checks++;
            if (busy !== 1'b0) begin
               n_fail++;
               $display("FAIL rst_mid_busy: got %b want 0", busy);
            end
            n_checks++;
            if (done !== 1'b0) begin
               n_fail++;
               $display("FAIL rst_mid_done: got %b want 0", done);
            end
            n_checks++;
            if (dut.lfsr_q !== m_lfsr) begin
               n_fail++;
               $display("FAIL rst_mid_lfsr: got %h want %h", dut.lfsr_q, m_lfsr);
            end
            return;
         end
         is_step = (e > 0) && (e <= h) && (e % T == 0);
         for (int j = 0; j < S; j++) if (e == sedge[j]) is_step = 1'b1;
         if (is_step) model_step(m_pre);
         n_checks++;
         if (value !== exp_value()) begin
            n_fail++;
            $display("FAIL roll_value h=%0d edge=%0d: got %h want %h", h, e, value, exp_value());
         end
         n_checks++;
         if (seg !== exp_seg()) begin
            n_fail++;
            $display("FAIL roll_seg h=%0d edge=%0d: got %h want %h", h, e, seg, exp_seg());
         end
         exp_b = (e < last);
         n_checks++;
         if (busy !== exp_b) begin
            n_fail++;
            $display("FAIL roll_busy h=%0d edge=%0d: got %b want %b", h, e, busy, exp_b);
         end
         exp_b = (e == last);
         n_checks++;
         if (done !== exp_b) begin
            n_fail++;
            $display("FAIL roll_done h=%0d edge=%0d: got %b want %b", h, e, done, exp_b);
         end
         if (done === 1'b1) pulses++;
      end
      roll  = chain;
      clear = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; roll = 1'b0; clear = 1'b0; roll2 = 1'b0;
      tick();
      tick();
      for (int i = 0; i < N; i++) mv[i] = 0;
      n_checks++;
      if (value !== '0) begin n_fail++; $display("FAIL reset_value: got %h want 0", value); end
      n_checks++;
      if (seg !== '0) begin n_fail++; $display("FAIL reset_seg: got %h want 0", seg); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      rst = 1'b0;
      n_checks++;
      if (dut.lfsr_q !== SEED) begin n_fail++; $display("FAIL reset_lfsr: got %h want %h", dut.lfsr_q, SEED); end
      tick();
      n_checks++;
      if (dut.lfsr_q !== m_lfsr) begin n_fail++; $display("FAIL lfsr_first_shift: got %h want %h", dut.lfsr_q, m_lfsr); end
   endtask

   task automatic test_decode();
      bit seen [8];
      logic [2:0] v;
      for (int i = 0; i < 8; i++) seen[i] = 1'b0;
      roll2 = 1'b1;
      for (int c = 0; c < 300; c++) begin
         tick();
         for (int d = 0; d < N2; d++) begin
            v = value2[3*d+:3];
            seen[v] = 1'b1;
            n_checks++;
            if (seg2[9*d+:9] !== SEG_TBL[v]) begin
               n_fail++;
               $display("FAIL decode die %0d value %0d: got %h want %h", d, v, seg2[9*d+:9], SEG_TBL[v]);
            end
         end
      end
      roll2 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (!seen[i]) begin n_fail++; $display("FAIL decode_cover: value %0d seen=0 want 1", i); end
      end
   endtask

   task automatic test_roll_timing();
      int p;
      do_roll(13, 1'b0, 1'b0, -1, p);
      n_checks++;
      if (p != 1) begin n_fail++; $display("FAIL timing_done_pulses: got %0d want 1", p); end
      for (int i = 0; i < N; i++) begin
         n_checks++;
         if (value[3*i+:3] < 3'd1 || value[3*i+:3] > 3'(MF)) begin
            n_fail++;
            $display("FAIL timing_range die %0d: got %0d want 1..%0d", i, value[3*i+:3], MF);
         end
      end
   endtask

   task automatic test_short_pulse();
      int p;
      do_roll(2, 1'b0, 1'b0, -1, p);
      n_checks++;
      if (p != 1) begin n_fail++; $display("FAIL short_done_pulses: got %0d want 1", p); end
   endtask

   task automatic test_wrap();
      int p;
      for (int r = 0; r < 1000; r++) begin
         do_roll(int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)), 1'b0, -1, p);
         for (int i = 0; i < N; i++) begin
            n_checks++;
            if (value[3*i+:3] < 3'd1 || value[3*i+:3] > 3'(MF)) begin
               n_fail++;
               $display("FAIL wrap_range roll %0d die %0d: got %0d want 1..%0d", r, i, value[3*i+:3], MF);
            end
         end
         n_checks++;
         if (p != 1) begin n_fail++; $display("FAIL wrap_done_pulses roll %0d: got %0d want 1", r, p); end
      end
      $display("info: %0d face wraps exercised", wraps);
   endtask

   task automatic test_ignore();
      int p;
      do_roll(7, 1'b1, 1'b0, -1, p);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int i = 0; i < N; i++) mv[i] = 0;
      n_checks++;
      if (value !== '0) begin n_fail++; $display("FAIL idle_clear_value: got %h want 0", value); end
      n_checks++;
      if (seg !== '0) begin n_fail++; $display("FAIL idle_clear_seg: got %h want 0", seg); end
   endtask

   task automatic test_back_to_back();
      int p;
      do_roll(5, 1'b0, 1'b1, -1, p);
      do_roll(6, 1'b0, 1'b0, -1, p);
      n_checks++;
      if (p != 1) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d want 1", p); end
   endtask

   task automatic test_reset_mid();
      int p;
      do_roll(5, 1'b0, 1'b0, 5 + 2 * T, p);
      for (int c = 0; c < 40; c++) begin
         tick();
         n_checks++;
         if (done !== 1'b0 || busy !== 1'b0 || value !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_after cycle %0d: got done=%b busy=%b value=%h want 0/0/0", c, done, busy, value);
         end
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_roll_timing();
      test_short_pulse();
      test_wrap();
      test_ignore();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
